// File: rtl/dsp_pkg.sv
// Shared op-codes and saturation mode constants for the accumulator bank.
// No logic of its own; pure declarations.
// No flow control.
package dsp_pkg;

   // Command op-codes carried on in_op
   typedef enum logic [1:0] {
      OP_MAC  = 2'b00,   // acc += a*b
      OP_MSU  = 2'b01,   // acc -= a*b
      OP_LOAD = 2'b10,   // acc  = sext(a)
      OP_CLR  = 2'b11    // acc  = 0, sticky overflow cleared
   } op_e;

   // Values for the SAT_EN parameter
   localparam int SAT_MODE  = 1;   // clamp to the most positive / most negative value
   localparam int WRAP_MODE = 0;   // keep the low ACC_W bits

endpackage

// File: rtl/accum_bank_if.sv
// Command and result channels of the accumulator bank.
// No logic; timing is set by the endpoints.
// in_* is valid/ready towards the bank, out_* is valid/ready from the bank.
interface accum_bank_if
   import dsp_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,
   parameter int NCH    = 16
);
   localparam int CH_W = $clog2(NCH);

   logic                     in_valid;
   logic                     in_ready;
   op_e                      in_op;
   logic [CH_W-1:0]          in_ch;
   logic signed [DATA_W-1:0] in_a;
   logic signed [DATA_W-1:0] in_b;

   logic                     out_valid;
   logic                     out_ready;
   logic [CH_W-1:0]          out_ch;
   logic [ACC_W-1:0]         out_data;
   logic                     out_ovf;

   // Command source / result sink side
   modport master (
      output in_valid, in_op, in_ch, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_ch, out_data, out_ovf
   );

   // Accumulator bank side
   modport slave (
      input  in_valid, in_op, in_ch, in_a, in_b, out_ready,
      output in_ready, out_valid, out_ch, out_data, out_ovf
   );

endinterface

// File: rtl/accum_bank_sat_add.sv
// Signed ACC_W add/subtract with one guard bit, saturating or wrapping result.
// Combinational, zero latency.
// No flow control.
module sat_add
   import dsp_pkg::*;
#(
   parameter int ACC_W  = 40,
   parameter int SAT_EN = SAT_MODE
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   input  logic             sub,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);
   localparam logic [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W:0] a_x;
   logic [ACC_W:0] b_x;
   logic [ACC_W:0] s_x;

   // One guard bit makes the exact result representable; overflow is guard != sign
   always_comb begin
      a_x = {a[ACC_W-1], a};
      b_x = {b[ACC_W-1], b};
      s_x = sub ? (a_x - b_x) : (a_x + b_x);
      ovf = s_x[ACC_W] ^ s_x[ACC_W-1];
      if (ovf && (SAT_EN != WRAP_MODE)) begin
         sum = s_x[ACC_W] ? NEG_MIN : POS_MAX;
      end else begin
         sum = s_x[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/accum_bank.sv
// NCH-channel signed multiply-accumulate bank with sticky per-channel overflow.
// Latency 2 cycles (S1 product register, S2 accumulate + output register), 1 cmd/cycle.
// in_ready = out_ready | ~out_valid; while low both stages hold and no channel is written.
module accum_bank
   import dsp_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40,          // must be at least 2*DATA_W
   parameter int NCH    = 16,          // must be at least 2
   parameter int SAT_EN = SAT_MODE
) (
   input  logic        clk,
   input  logic        reset,
   accum_bank_if.slave bus
);
   localparam int            CH_W   = $clog2(NCH);
   localparam int            PROD_W = 2 * DATA_W;
   localparam logic [CH_W:0] NCH_L  = (CH_W+1)'(NCH);

   logic                     stall;

   // S1: decoded command with the operand already in full precision
   logic                     s1_vld;
   op_e                      s1_op;
   logic [CH_W-1:0]          s1_ch;
   logic signed [PROD_W-1:0] s1_val;
   logic signed [PROD_W-1:0] a_ext;
   logic signed [PROD_W-1:0] b_ext;

   // Channel state
   logic [ACC_W-1:0]         acc_q [NCH];
   logic [NCH-1:0]           ovf_q;

   // S2 datapath
   logic                     ch_ok;
   logic [ACC_W-1:0]         acc_rd;
   logic                     ovf_rd;
   logic [ACC_W-1:0]         opnd;
   logic                     sub_op;
   logic [ACC_W-1:0]         sum;
   logic                     add_ovf;
   logic [ACC_W-1:0]         nxt_acc;
   logic                     nxt_ovf;

   // Output register
   logic                     out_vld_q;
   logic [CH_W-1:0]          out_ch_q;
   logic [ACC_W-1:0]         out_data_q;
   logic                     out_ovf_q;

   assign stall         = out_vld_q & ~bus.out_ready;
   assign bus.in_ready  = ~stall;
   assign bus.out_valid = out_vld_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ovf   = out_ovf_q;

   assign a_ext  = PROD_W'(bus.in_a);
   assign b_ext  = PROD_W'(bus.in_b);
   assign sub_op = (s1_op == OP_MSU);

   // S1: register command; LOAD carries sext(a), CLR carries zero, MAC/MSU carry a*b
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld <= 1'b0;
         s1_op  <= OP_MAC;
         s1_ch  <= '0;
         s1_val <= '0;
      end else if (!stall) begin
         s1_vld <= bus.in_valid;
         s1_op  <= bus.in_op;
         s1_ch  <= bus.in_ch;
         case (bus.in_op)
            OP_MAC, OP_MSU: s1_val <= a_ext * b_ext;
            OP_LOAD:        s1_val <= a_ext;
            default:        s1_val <= '0;
         endcase
      end
   end

   // S2 read side: out-of-range channels read as zero and never write back
   always_comb begin
      ch_ok  = ({1'b0, s1_ch} < NCH_L);
      acc_rd = '0;
      ovf_rd = 1'b0;
      if (ch_ok) begin
         acc_rd = acc_q[s1_ch];
         ovf_rd = ovf_q[s1_ch];
      end
      opnd = ACC_W'(s1_val);
   end

   sat_add #(
      .ACC_W  (ACC_W),
      .SAT_EN (SAT_EN)
   ) u_sat_add (
      .a   (acc_rd),
      .b   (opnd),
      .sub (sub_op),
      .sum (sum),
      .ovf (add_ovf)
   );

   // Next channel value and sticky flag per op
   always_comb begin
      nxt_acc = sum;
      nxt_ovf = ovf_rd | add_ovf;
      case (s1_op)
         OP_LOAD: begin
            nxt_acc = opnd;
            nxt_ovf = ovf_rd;
         end
         OP_CLR: begin
            nxt_acc = '0;
            nxt_ovf = 1'b0;
         end
         default: ;
      endcase
      if (!ch_ok) begin
         nxt_acc = '0;
         nxt_ovf = 1'b0;
      end
   end

   // S2 write side: channel state updates only when S2 advances with a valid command
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            acc_q[i] <= '0;
         end
         ovf_q <= '0;
      end else if (!stall && s1_vld && ch_ok) begin
         acc_q[s1_ch] <= nxt_acc;
         ovf_q[s1_ch] <= nxt_ovf;
      end
   end

   // Output register: a bubble in S1 drops out_valid once the current result moves on
   always_ff @(posedge clk) begin
      if (reset) begin
         out_vld_q  <= 1'b0;
         out_ch_q   <= '0;
         out_data_q <= '0;
         out_ovf_q  <= 1'b0;
      end else if (!stall) begin
         out_vld_q <= s1_vld;
         if (s1_vld) begin
            out_ch_q   <= s1_ch;
            out_data_q <= nxt_acc;
            out_ovf_q  <= nxt_ovf;
         end
      end
   end

endmodule

// File: tb/tb_accum_bank.sv
// Scoreboard bench: one saturating and one wrapping bank driven by the same commands.
// Expected results are queued at accept time and popped by a monitor on each transfer.
// Covers reset state, MAC/MSU/LOAD/CLR, overflow, stall, and reset with commands in flight.
module tb_accum_bank;
   import dsp_pkg::*;

   localparam int DW  = 16;
   localparam int AW  = 40;
   localparam int NCH = 16;
   localparam int CW  = 4;
   localparam longint MAXV = (longint'(1) <<< (AW-1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (AW-1));

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 in_valid = 1'b0;
   logic [1:0]           in_op = 2'b00;
   logic [CW-1:0]        in_ch = '0;
   logic signed [DW-1:0] in_a = '0;
   logic signed [DW-1:0] in_b = '0;
   logic                 out_ready = 1'b1;

   always #5 clk = ~clk;

   accum_bank_if #(.DATA_W(DW), .ACC_W(AW), .NCH(NCH)) if_s ();
   accum_bank_if #(.DATA_W(DW), .ACC_W(AW), .NCH(NCH)) if_w ();

   assign if_s.in_valid  = in_valid;
   assign if_s.in_op     = op_e'(in_op);
   assign if_s.in_ch     = in_ch;
   assign if_s.in_a      = in_a;
   assign if_s.in_b      = in_b;
   assign if_s.out_ready = out_ready;
   assign if_w.in_valid  = in_valid;
   assign if_w.in_op     = op_e'(in_op);
   assign if_w.in_ch     = in_ch;
   assign if_w.in_a      = in_a;
   assign if_w.in_b      = in_b;
   assign if_w.out_ready = out_ready;

   accum_bank #(.DATA_W(DW), .ACC_W(AW), .NCH(NCH), .SAT_EN(1)) u_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (if_s.slave)
   );

   accum_bank #(.DATA_W(DW), .ACC_W(AW), .NCH(NCH), .SAT_EN(0)) u_wrap (
      .clk   (clk),
      .reset (reset),
      .bus   (if_w.slave)
   );

   typedef struct {
      logic [CW-1:0] ch;
      logic [AW-1:0] data;
      logic          ovf;
      int            acc_cyc;
      bit            chk_lat;
      int            id;
   } exp_t;

   exp_t   q_s[$];
   exp_t   q_w[$];
   longint m_acc [2][NCH];
   bit     m_ovf [2][NCH];
   int     cyc = 0;
   int     id_n = 0;
   int     n_vec = 0;
   int     n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s #%0d: got %h, expected %h", name, id, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input exp_t e, input logic [CW-1:0] ch,
                            input logic [AW-1:0] d, input logic o);
      chk({tag, "_ch"},   e.id, 64'(ch), 64'(e.ch));
      chk({tag, "_data"}, e.id, 64'(d),  64'(e.data));
      chk({tag, "_ovf"},  e.id, 64'(o),  64'(e.ovf));
      if (e.chk_lat) chk({tag, "_latency"}, e.id, 64'(cyc - e.acc_cyc + 1), 64'd2);
   endtask

   // Behavioural reference: exact 64-bit arithmetic, then clamp or wrap into AW bits
   task automatic model(input int md, input logic [1:0] op, input int ch,
                        input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                        output logic [AW-1:0] d, output logic o);
      longint p;
      longint s;
      bit     of;
      p  = longint'(a) * longint'(b);
      s  = m_acc[md][ch];
      of = 1'b0;
      case (op)
         2'd0:    s = s + p;
         2'd1:    s = s - p;
         2'd2:    s = longint'(a);
         default: s = 0;
      endcase
      if (op < 2'd2 && (s > MAXV || s < MINV)) begin
         of = 1'b1;
         if (md == 0) begin
            s = (s > MAXV) ? MAXV : MINV;
         end else begin
            s = s & ((longint'(1) <<< AW) - 1);
            if (s > MAXV) s = s - (longint'(1) <<< AW);
         end
      end
      m_acc[md][ch] = s;
      if (op == 2'd3) m_ovf[md][ch] = 1'b0;
      else if (op < 2'd2) m_ovf[md][ch] = m_ovf[md][ch] | of;
      d = s[AW-1:0];
      o = m_ovf[md][ch];
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input logic [1:0] op, input int ch, input int a, input int b,
                       input bit hand, input logic [AW-1:0] hs_d, input logic hs_o,
                       input logic [AW-1:0] hw_d, input logic hw_o, input bit lat,
                       output int waited);
      exp_t          e;
      logic [AW-1:0] md;
      logic          mo;
      bit            rdy;
      in_valid = 1'b1;
      in_op    = op;
      in_ch    = ch[CW-1:0];
      in_a     = a[DW-1:0];
      in_b     = b[DW-1:0];
      waited   = 0;
      rdy      = 1'b0;
      while (!rdy && waited < 50) begin
         @(negedge clk);
         rdy = if_s.in_ready && if_w.in_ready;
         @(posedge clk);
         if (!rdy) waited++;
      end
      #1;
      in_valid = 1'b0;
      id_n++;
      if (!rdy) begin
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout #%0d: in_ready stayed %b/%b, expected 1", id_n, if_s.in_ready, if_w.in_ready);
      end else begin
         e.ch = ch[CW-1:0];
         e.acc_cyc = cyc;
         e.chk_lat = lat;
         e.id = id_n;
         model(0, op, ch, in_a, in_b, md, mo);
         e.data = hand ? hs_d : md;
         e.ovf  = hand ? hs_o : mo;
         q_s.push_back(e);
         model(1, op, ch, in_a, in_b, md, mo);
         e.data = hand ? hw_d : md;
         e.ovf  = hand ? hw_o : mo;
         q_w.push_back(e);
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((q_s.size() != 0 || q_w.size() != 0) && t < 100) begin
         @(posedge clk);
         t++;
      end
      if (q_s.size() != 0 || q_w.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", q_s.size(), q_w.size());
      end
      #1;
   endtask

   // Monitor: every transfer on either bank must match the head of its queue
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (if_s.out_valid && if_s.out_ready) begin
            if (q_s.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL sat_unexpected: ch %0d data %h, expected no result", if_s.out_ch, if_s.out_data);
            end else begin
               e = q_s.pop_front();
               check_out("sat", e, if_s.out_ch, if_s.out_data, if_s.out_ovf);
            end
         end
         if (if_w.out_valid && if_w.out_ready) begin
            if (q_w.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL wrap_unexpected: ch %0d data %h, expected no result", if_w.out_ch, if_w.out_data);
            end else begin
               e = q_w.pop_front();
               check_out("wrap", e, if_w.out_ch, if_w.out_data, if_w.out_ovf);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int w1;
      int w2;
      int wd;
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < NCH; c++) begin
            m_acc[m][c] = 0;
            m_ovf[m][c] = 1'b0;
         end
      end

      // Reset state, with out_ready low so in_ready depends on out_valid
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid_s", 0, 64'(if_s.out_valid), 64'd0);
      chk("rst_out_valid_w", 0, 64'(if_w.out_valid), 64'd0);
      chk("rst_out_data_s",  0, 64'(if_s.out_data),  64'd0);
      chk("rst_out_ch_s",    0, 64'(if_s.out_ch),    64'd0);
      chk("rst_out_ovf_s",   0, 64'(if_s.out_ovf),   64'd0);
      chk("rst_in_ready_s",  0, 64'(if_s.in_ready),  64'd1);
      chk("rst_in_ready_w",  0, 64'(if_w.in_ready),  64'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;

      // First result and its latency
      send(OP_MAC, 8, 1, 1, 1'b1, 40'd1, 1'b0, 40'd1, 1'b0, 1'b1, wd);
      drain();

      // Back-to-back on one channel sees the previous result with no wait
      send(OP_MAC, 9, 1, 3, 1'b1, 40'd3,  1'b0, 40'd3,  1'b0, 1'b0, w1);
      send(OP_MAC, 9, 2, 5, 1'b1, 40'd13, 1'b0, 40'd13, 1'b0, 1'b0, w2);
      chk("b2b_ready_wait", 2, 64'(w2), 64'd0);
      send(OP_MSU, 9, 4, 4, 1'b1, 40'hFF_FFFF_FFFD, 1'b0, 40'hFF_FFFF_FFFD, 1'b0, 1'b0, wd);
      send(OP_LOAD, 2, -2, 7, 1'b1, 40'hFF_FFFF_FFFE, 1'b0, 40'hFF_FFFF_FFFE, 1'b0, 1'b0, wd);
      drain();

      // Overflow ramp: 0x7FFF + 1024 * 0x3FFF0001 exceeds 2^39
      send(OP_LOAD, 3, 16'h7FFF, 0, 1'b1, 40'h7FFF, 1'b0, 40'h7FFF, 1'b0, 1'b0, wd);
      for (int i = 0; i < 1024; i++) begin
         if (i == 1023)
            send(OP_MAC, 3, 16'h7FFF, 16'h7FFF, 1'b1, 40'h7F_FFFF_FFFF, 1'b1, 40'hFF_FC00_83FF, 1'b1, 1'b0, wd);
         else
            send(OP_MAC, 3, 16'h7FFF, 16'h7FFF, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, wd);
      end
      send(OP_LOAD, 3, 1, 0, 1'b1, 40'd1, 1'b1, 40'd1, 1'b1, 1'b0, wd);
      send(OP_CLR,  3, 9, 9, 1'b1, 40'd0, 1'b0, 40'd0, 1'b0, 1'b0, wd);
      drain();

      // Stall: result held, in_ready low, queued commands finish in order afterwards
      out_ready = 1'b0;
      fork
         begin
            int ws;
            send(OP_LOAD, 10, 5, 0, 1'b1, 40'd5, 1'b0, 40'd5, 1'b0, 1'b0, ws);
            send(OP_MAC,  10, 1, 1, 1'b1, 40'd6, 1'b0, 40'd6, 1'b0, 1'b0, ws);
            send(OP_MAC,  10, 1, 1, 1'b1, 40'd7, 1'b0, 40'd7, 1'b0, 1'b0, ws);
            send(OP_MAC,  10, 1, 1, 1'b1, 40'd8, 1'b0, 40'd8, 1'b0, 1'b0, ws);
         end
         begin
            int t = 0;
            @(negedge clk);
            while (!if_s.out_valid && t < 20) begin
               @(negedge clk);
               t++;
            end
            for (int k = 0; k < 3; k++) begin
               if (k > 0) @(negedge clk);
               chk("stall_in_ready_s", k, 64'(if_s.in_ready), 64'd0);
               chk("stall_in_ready_w", k, 64'(if_w.in_ready), 64'd0);
               chk("stall_hold_data_s", k, 64'(if_s.out_data), 64'd5);
               chk("stall_hold_data_w", k, 64'(if_w.out_data), 64'd5);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two MACs to ch5 in flight; nothing of them may survive
      send(OP_MAC, 5, 7, 7, 1'b1, 40'd49, 1'b0, 40'd49, 1'b0, 1'b0, wd);
      send(OP_MAC, 5, 7, 7, 1'b1, 40'd98, 1'b0, 40'd98, 1'b0, 1'b0, wd);
      reset = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 reset = 1'b0;
      q_s.delete();
      q_w.delete();
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < NCH; c++) begin
            m_acc[m][c] = 0;
            m_ovf[m][c] = 1'b0;
         end
      end
      @(negedge clk);
      chk("mid_rst_out_valid_s", 0, 64'(if_s.out_valid), 64'd0);
      chk("mid_rst_out_valid_w", 0, 64'(if_w.out_valid), 64'd0);
      @(posedge clk);
      #1;
      send(OP_MSU, 5, 2, 3, 1'b1, 40'hFF_FFFF_FFFA, 1'b0, 40'hFF_FFFF_FFFA, 1'b0, 1'b0, wd);
      drain();

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
